// File: rtl/multiplier.sv
// Sequential RV32M multiplier (MUL/MULH/MULHSU/MULHU): radix-2 shift-add over operand magnitudes, then sign fixup.
// Latency: 34 cycles from accepted start to done pulse; one operation per 35 cycles.
// Backpressure: busy is high outside IDLE, start is ignored (not queued) while busy, flush aborts to IDLE.
module multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [1:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] f
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   ma_q, ma_d;
  logic [WIDTH-1:0]   mb_q, mb_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic [1:0]         funct_q, funct_d;
  logic [WIDTH-1:0]   f_q, f_d;

  logic               a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; flush wins over start and over normal progression
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start && !flush) state_d = S_CALC;
      S_CALC:  if (flush) state_d = S_IDLE;
               else if (cnt_q == LAST_CNT) state_d = S_FIXUP;
      S_FIXUP: state_d = flush ? S_IDLE : S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from registered state only, so no path from start to busy
  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
    f    = f_q;
  end

  // Datapath next-state: operand capture, shift-add step, sign fixup
  always_comb begin
    a_signed = (funct != 2'b11);
    b_signed = !funct[1];
    a_neg    = a_signed && a[WIDTH-1];
    b_neg    = b_signed && b[WIDTH-1];
    // the carry out of the upper-half add becomes the new MSB after the shift
    sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (mb_q[0] ? ma_q : '0)};
    prod     = neg_q ? -acc_q : acc_q;

    acc_d   = acc_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    funct_d = funct_q;
    f_d     = f_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          funct_d = funct;
          neg_d   = a_neg ^ b_neg;
          ma_d    = a_neg ? -a : a;   // 0x80000000 stays 2^31 as an unsigned magnitude
          mb_d    = b_neg ? -b : b;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      S_CALC: begin
        acc_d = {sum, acc_q[WIDTH-1:1]};
        mb_d  = mb_q >> 1;
        cnt_d = cnt_q + 1'b1;
      end
      S_FIXUP: begin
        if (!flush) f_d = (funct_q == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      funct_q <= 2'b00;
      f_q     <= '0;
    end else begin
      acc_q   <= acc_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      funct_q <= funct_d;
      f_q     <= f_d;
    end
  end

endmodule
